// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: FSM encoding, default widths and
// the MAC pipeline depth that sets forget/oe timing.
package mac_sequencer_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;

    // MAC core latency: one input-register stage plus the accumulator.
    localparam int unsigned MAC_LAT = 2;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StCapture
    } state_e;

endpackage

// File: rtl/mac_seq_valid_pipe.sv
// Delays the fetch strobe to gate memory read data onto the MAC ports, and
// delays the first-index flag so forget lands on the first product.
module mac_seq_valid_pipe
    import mac_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic fetch_i,
    input  logic first_i,
    output logic data_en_o,
    output logic forget_o
);

    logic               valid_q, valid_d;
    logic [MAC_LAT-1:0] first_q, first_d;

    always_comb begin
        valid_d = fetch_i;
        first_d = {first_q[MAC_LAT-2:0], first_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            first_q <= '0;
        end else begin
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    assign data_en_o = valid_q;
    assign forget_o  = first_q[MAC_LAT-1];

endmodule

// File: rtl/mac_sequencer.sv
// Streams weight/input vectors from two sync-read memories into a MAC core and
// captures the dot product. Define MAC_SEQ_RELU_EN to apply ReLU at capture.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] w_base,
    output logic              busy,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] w_rd_data,
    input  logic [DATA_W-1:0] x_rd_data,
    output logic [DATA_W-1:0] mac_weight,
    output logic [DATA_W-1:0] mac_in,
    output logic              mac_forget,
    output logic              mac_oe,
    input  logic [DATA_W-1:0] mac_out,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(1 << ADDR_W);
    localparam logic [1:0]       DrainEnd = 2'(MAC_LAT - 1);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [1:0]          drain_q, drain_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_valid_q, result_valid_d;

    logic                fetch, first, data_en;
    logic [LEN_W-1:0]    len_clamped;

    assign len_clamped = (len > MaxLen) ? MaxLen : len;

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        base_d         = base_q;
        idx_d          = idx_q;
        drain_d        = drain_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        fetch          = 1'b0;
        first          = 1'b0;
        mac_oe         = 1'b0;
        w_addr         = '0;
        x_addr         = '0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (len == '0) begin
                        // Empty vector: report a zero result without touching the MAC.
                        result_d       = '0;
                        result_valid_d = 1'b1;
                    end else begin
                        len_d   = len_clamped;
                        base_d  = w_base;
                        idx_d   = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                fetch  = 1'b1;
                first  = (idx_q == '0);
                w_addr = base_q + idx_q[ADDR_W-1:0];
                x_addr = idx_q[ADDR_W-1:0];
                if (idx_q == len_q - LEN_W'(1)) begin
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            StDrain: begin
                // Let the last product pass the MAC input regs and accumulator.
                if (drain_q == DrainEnd) begin
                    state_d = StCapture;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            StCapture: begin
                mac_oe = 1'b1;
`ifdef MAC_SEQ_RELU_EN
                result_d = mac_out[DATA_W-1] ? '0 : mac_out;
`else
                result_d = mac_out;
`endif
                result_valid_d = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            len_q          <= '0;
            base_q         <= '0;
            idx_q          <= '0;
            drain_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            base_q         <= base_d;
            idx_q          <= idx_d;
            drain_q        <= drain_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    mac_seq_valid_pipe u_valid_pipe (
        .clk       (clk),
        .reset     (reset),
        .fetch_i   (fetch),
        .first_i   (first),
        .data_en_o (data_en),
        .forget_o  (mac_forget)
    );

    // Zero outside valid slots so stray MAC products contribute nothing.
    assign mac_weight   = data_en ? w_rd_data : '0;
    assign mac_in       = data_en ? x_rd_data : '0;
    assign busy         = (state_q != StIdle);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural MAC core and 1-cycle memories, with a
// scoreboard of dot-product results computed directly from memory contents.
module tb_mac_sequencer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int LW = 5;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic [AW-1:0] w_base = '0;
    logic          busy;
    logic [AW-1:0] w_addr, x_addr;
    logic [DW-1:0] w_rd_data, x_rd_data;
    logic [DW-1:0] mac_weight, mac_in;
    logic          mac_forget, mac_oe;
    logic [DW-1:0] mac_out;
    logic [DW-1:0] result;
    logic          result_valid;

    mac_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .w_base       (w_base),
        .busy         (busy),
        .w_addr       (w_addr),
        .x_addr       (x_addr),
        .w_rd_data    (w_rd_data),
        .x_rd_data    (x_rd_data),
        .mac_weight   (mac_weight),
        .mac_in       (mac_in),
        .mac_forget   (mac_forget),
        .mac_oe       (mac_oe),
        .mac_out      (mac_out),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memories with one cycle of read latency.
    logic [DW-1:0] wmem [DEPTH];
    logic [DW-1:0] xmem [DEPTH];
    always @(posedge clk) begin
        w_rd_data <= wmem[w_addr];
        x_rd_data <= xmem[x_addr];
    end

    // MAC core: input registers then accumulator, tri-stated output.
    logic [DW-1:0] mw_q, mx_q, acc_q;
    logic [15:0]   prod;
    assign prod = 16'(mw_q) * 16'(mx_q);
    always @(posedge clk) begin
        if (reset) begin
            mw_q  <= '0;
            mx_q  <= '0;
            acc_q <= '0;
        end else begin
            mw_q  <= mac_weight;
            mx_q  <= mac_in;
            acc_q <= mac_forget ? prod[7:0] : acc_q + prod[7:0];
        end
    end
    assign mac_out = mac_oe ? acc_q : 'z;

    int n_checks = 0;
    int n_fail = 0;
    int forget_cnt = 0;
    int oe_cnt = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain dot product over the (clamped) vector, mod 256.
    function automatic logic [DW-1:0] ref_dot(input int l, input int base);
        int leff;
        int s;
        leff = (l > DEPTH) ? DEPTH : l;
        s = 0;
        for (int i = 0; i < leff; i++) s += int'(wmem[(base + i) % DEPTH]) * int'(xmem[i]);
        s = s % 256;
`ifdef MAC_SEQ_RELU_EN
        if (s >= 128) s = 0;
`endif
        return DW'(s);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (mac_forget) forget_cnt++;
        if (mac_oe) oe_cnt++;
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.data));
                check("result_latency", cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input int l, input int base, input bit ghost_start);
        int   leff;
        int   cs;
        exp_t e;
        leff = (l > DEPTH) ? DEPTH : l;
        @(posedge clk); #1;
        start  = 1'b1;
        len    = LW'(l);
        w_base = AW'(base);
        cs     = cyc;
        forget_cnt = 0;
        oe_cnt     = 0;
        e.data = ref_dot(l, base);
        e.cyc  = (l == 0) ? cs + 1 : cs + leff + 4;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < leff; i++) begin
            check("w_addr", 32'(w_addr), 32'((base + i) % DEPTH));
            check("x_addr", 32'(x_addr), 32'(i));
            check("busy_fetch", 32'(busy), 32'd1);
            if (ghost_start && i == 1) begin
                start = 1'b1;
                len   = LW'(1);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            check("result_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        repeat (8) @(posedge clk);
        #1;
        check("forget_pulses", forget_cnt, (l != 0) ? 1 : 0);
        check("oe_pulses", oe_cnt, (l != 0) ? 1 : 0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            wmem[i] = DW'($urandom);
            xmem[i] = DW'($urandom);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            wmem[i] = '0;
            xmem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_x_addr", 32'(x_addr), 32'd0);
        check("rst_mac_weight", 32'(mac_weight), 32'd0);
        check("rst_mac_in", 32'(mac_in), 32'd0);
        check("rst_mac_forget", 32'(mac_forget), 32'd0);
        check("rst_mac_oe", 32'(mac_oe), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);

        // Basic dot product: 2*5 + 3*6 + 4*7 = 56.
        wmem[0] = 8'd2; wmem[1] = 8'd3; wmem[2] = 8'd4;
        xmem[0] = 8'd5; xmem[1] = 8'd6; xmem[2] = 8'd7;
        run_op(3, 0, 1'b0);
        check("basic_value", 32'(result), 32'h38);

        // Reset in the second FETCH cycle aborts with everything cleared.
        @(posedge clk); #1;
        start = 1'b1; len = LW'(4); w_base = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mac_oe", 32'(mac_oe), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        check("abort_forget", 32'(mac_forget), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        run_op(3, 0, 1'b0);

        // Overflow wraps, then forget must discard the old sum.
        wmem[0] = 8'd16; wmem[1] = 8'd16;
        xmem[0] = 8'd16; xmem[1] = 8'd1;
        run_op(2, 0, 1'b0);
        check("wrap_value", 32'(result), 32'h10);
        wmem[0] = 8'd1; xmem[0] = 8'd1;
        run_op(1, 0, 1'b0);
        check("forget_value", 32'(result), 32'h01);

        // Negative-looking sum: passes through, or ReLU clamps to zero.
        wmem[0] = 8'hFF; xmem[0] = 8'd1;
        run_op(1, 0, 1'b0);

        // Weight address wrap with a start pulse while busy.
        fill_random();
        run_op(4, 14, 1'b1);

        // Zero-length request.
        run_op(0, 5, 1'b0);

        // Over-length request is clamped to the memory depth.
        fill_random();
        run_op(20, 3, 1'b0);

        for (int n = 0; n < 25; n++) begin
            fill_random();
            run_op(int'($urandom_range(0, 20)), int'($urandom_range(0, DEPTH - 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
